// File: rtl/seq_sub32.sv
// seq_sub32: multi-cycle ripple-borrow subtractor, one slice per clock.
// Computes a - b - bin with valid/ready handshakes on both sides.
module seq_sub32 #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] diff_nx;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [SLICE:0]   sum;
  logic             last;

  // Current slice: a_s + ~b_s + carry, merged into the partial difference
  always_comb begin
    sum = {1'b0, ra[int'(cnt)*SLICE +: SLICE]}
        + {1'b0, ~rb[int'(cnt)*SLICE +: SLICE]}
        + {{SLICE{1'b0}}, carry};
    diff_nx = diff;
    diff_nx[int'(cnt)*SLICE +: SLICE] = sum[SLICE-1:0];
    last = (cnt == LAST);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and handshake outputs
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = BUSY;
      end
      BUSY: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, per-slice datapath and final flags
  always_ff @(posedge clk) begin
    if (rst) begin
      ra    <= '0;
      rb    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
      zero  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            ra    <= a;
            rb    <= b;
            carry <= ~bin;
            cnt   <= '0;
          end
        end
        BUSY: begin
          diff  <= diff_nx;
          carry <= sum[SLICE];
          if (last) begin
            bout <= ~sum[SLICE];
            zero <= (diff_nx == '0);
            ovf  <= (ra[WIDTH-1] != rb[WIDTH-1])
                 && (diff_nx[WIDTH-1] != ra[WIDTH-1]);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_sub32.sv
// tb_seq_sub32: table vectors, corner sequences and random ops
// checked through an expected-result queue.
module tb_seq_sub32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        bin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] diff;
  logic        bout;
  logic        zero;
  logic        ovf;

  seq_sub32 #(.WIDTH(32), .SLICE(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        bo;
    logic        z;
    logic        o;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic [31:0] d;
    logic        bo;
    logic        z;
    logic        o;
  } vec_t;

  res_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  function automatic res_t model(input logic [31:0] xa,
                                 input logic [31:0] xb,
                                 input logic xbin);
    res_t        r;
    logic [32:0] t;
    t    = {1'b0, xa} - {1'b0, xb} - {32'b0, xbin};
    r.d  = t[31:0];
    r.bo = t[32];
    r.z  = (t[31:0] == 32'h0);
    r.o  = (xa[31] != xb[31]) && (t[31] != xa[31]);
    return r;
  endfunction

  task automatic send(input logic [31:0] xa, input logic [31:0] xb,
                      input logic xbin, input res_t e);
    for (int k = 0; k < 50 && !in_ready; k++) @(negedge clk);
    chk1("send_ready", in_ready, 1'b1);
    sbq.push_back(e);
    a        = xa;
    b        = xb;
    bin      = xbin;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    bin      = 1'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk1("out_valid_wait", out_valid, 1'b1);
  endtask

  task automatic cmp_out();
    res_t e;
    if (sbq.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL sb_underflow: got result %h expected none", diff);
    end else begin
      e = sbq.pop_front();
      chk("diff", diff, e.d);
      chk1("bout", bout, e.bo);
      chk1("zero", zero, e.z);
      chk1("ovf", ovf, e.o);
    end
  endtask

  task automatic recv(input int stall, output int lat);
    logic [31:0] snap;
    wait_valid(lat);
    snap = diff;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_diff", diff, snap);
      chk1("stall_ready", in_ready, 1'b0);
    end
    cmp_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk1("ready_after_out", in_ready, 1'b1);
    chk1("valid_after_out", out_valid, 1'b0);
  endtask

  vec_t tbl[7];

  initial begin
    int          lat;
    logic [31:0] snap;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rbin;
    res_t        e;

    tbl[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0,
               32'h0000_0002, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{32'h0000_0100, 32'h0000_0001, 1'b0,
               32'h0000_00FF, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{32'h0000_0000, 32'h0000_0001, 1'b0,
               32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{32'h8000_0000, 32'h0000_0001, 1'b0,
               32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{32'h1234_5678, 32'h1234_5677, 1'b1,
               32'h0000_0000, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{32'h0000_0000, 32'h0000_0000, 1'b1,
               32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0,
               32'h8000_0000, 1'b1, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_diff", diff, 32'h0);
    chk1("rst_bout", bout, 1'b0);
    chk1("rst_zero", zero, 1'b0);
    chk1("rst_ovf", ovf, 1'b0);

    foreach (tbl[i]) begin
      e = '{tbl[i].d, tbl[i].bo, tbl[i].z, tbl[i].o};
      send(tbl[i].a, tbl[i].b, tbl[i].bin, e);
      recv(i % 3, lat);
      chk("latency", 32'(lat), 32'd4);
    end

    send(32'h0000_0009, 32'h0000_0004, 1'b0,
         '{32'h0000_0005, 1'b0, 1'b0, 1'b0});
    wait_valid(lat);
    snap     = diff;
    in_valid = 1'b1;
    a        = 32'h0000_0020;
    b        = 32'h0000_0008;
    bin      = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk1("bp_in_ready", in_ready, 1'b0);
      chk1("bp_out_valid", out_valid, 1'b1);
      chk("bp_diff", diff, snap);
    end
    cmp_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk1("bp_ready_next", in_ready, 1'b1);
    sbq.push_back('{32'h0000_0017, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    in_valid = 1'b0;
    recv(0, lat);
    chk("bp_latency", 32'(lat), 32'd4);

    send(32'h0000_0055, 32'h0000_0011, 1'b0, model(32'h55, 32'h11, 1'b0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(sbq.pop_back());
    chk1("abort_in_ready", in_ready, 1'b1);
    chk1("abort_out_valid", out_valid, 1'b0);
    chk("abort_diff", diff, 32'h0);
    chk1("abort_bout", bout, 1'b0);
    chk1("abort_zero", zero, 1'b0);
    chk1("abort_ovf", ovf, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk1("abort_quiet", out_valid, 1'b0);
    end
    send(32'h0000_0007, 32'h0000_0003, 1'b0,
         '{32'h0000_0004, 1'b0, 1'b0, 1'b0});
    recv(0, lat);

    for (int i = 0; i < 20; i++) begin
      ra   = $urandom;
      rb   = (i % 5 == 0) ? ra : $urandom;
      rbin = (i % 5 == 0) ? 1'b0 : 1'($urandom);
      send(ra, rb, rbin, model(ra, rb, rbin));
      recv($urandom_range(0, 3), lat);
      chk("rnd_latency", 32'(lat), 32'd4);
    end

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_sub32.md
# seq_sub32

Multi-cycle ripple-borrow subtractor. It computes `a - b - bin` one SLICE-bit slice per clock and returns the difference, a borrow-out and status flags over valid/ready handshakes. It is the subtract-direction companion to the team's combinational 8-bit-sliced ripple-carry adder. It sits in the same datapath wherever a registered, low-area subtract with flow control is needed.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must be a multiple of SLICE
- SLICE, 8, bits processed per cycle; N = WIDTH/SLICE slices

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operands presented
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow-in
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
- bout  output  1  borrow-out; 1 when unsigned a < b + bin
- zero  output  1  diff == 0
- ovf  output  1  signed two's-complement overflow

## Operation
- Arithmetic: each slice computes a_s + ~b_s + c; c starts at ~bin; carry between slices is registered; final bout = ~carry_out of slice N-1.
- ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]).
- Operands a, b and bin are captured into internal registers on input handshake. Later changes on input pins have no effect.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. in_valid=1 captures operands, clears slice counter, goes to BUSY.
  - BUSY: in_ready=0. One slice per cycle, LSB slice first, written into diff[k*SLICE +: SLICE]. After slice N-1 completes, registers bout/zero/ovf and goes to DONE.
  - DONE: out_valid=1, in_ready=0. diff/bout/zero/ovf held stable. out_ready=1 goes to IDLE.
- No overlap: a new operand set is never accepted in the cycle a result is consumed.
- in_valid while not in IDLE is ignored and no state is altered.
- Slice counter is log2(N) bits and never wraps in normal operation; it is cleared on entry to BUSY.

## Timing
- Reset: state=IDLE; in_ready=1 on the first cycle after rst deasserts. out_valid=0; diff=0, bout=0, zero=0, ovf=0; internal operand and carry registers=0.
- rst asserted in any state (including mid-BUSY or DONE) aborts the operation at the next edge; the partial result is discarded and out_valid is never raised for it.
- Latency: with the input handshake at edge E0, slice k is computed at edge E(k+1). out_valid is high from the cycle after edge EN, i.e. N cycles after acceptance (4 for defaults).
- Output handshake completes at the edge where out_valid && out_ready. in_ready is high the following cycle.
- Best-case throughput: one operation per N+2 cycles.
- Outputs are registered. diff, bout, zero and ovf are valid only while out_valid=1. During BUSY, diff shows partially written slices.

## Test plan
- a=0x0000_0005, b=0x0000_0003, bin=0 -> diff=0x0000_0002, bout=0, zero=0, ovf=0. out_valid rises exactly 4 cycles after accept.
- a=0x0000_0100, b=0x0000_0001, bin=0 (inter-slice borrow) -> diff=0x0000_00FF, bout=0. Also a=0, b=1 -> diff=0xFFFF_FFFF, bout=1, ovf=0.
- a=0x8000_0000, b=0x0000_0001 -> diff=0x7FFF_FFFF, bout=0, ovf=1. Also a=0x1234_5678, b=0x1234_5677, bin=1 -> diff=0, zero=1, bout=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 with new operands -> in_ready=0 throughout, outputs unchanged. After out_ready=1, in_ready=1 next cycle and the new operands are accepted.
- Reset at the second BUSY cycle -> out_valid stays 0, all outputs 0, in_ready=1 the cycle after rst drops. The next operation 7-3 yields diff=4.
- Back-to-back: 20 random operand sets with random out_ready stalls, checked against a reference model of a-b-bin, bout and ovf. No lost or duplicated results.
